// File: rtl/dmem_pkg.sv
// Shared data-memory types: request control flags, arbiter states and bus widths.
// Used by the arbiter, the memory stage and the data-memory model.
package dmem_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned CTL_W    = 3;
  localparam int unsigned TIMER_W  = 8;
  localparam int unsigned STARVE_W = 3;

  // Access qualifiers: unsigned load, halfword, byte.
  typedef struct packed {
    logic rdu;
    logic hwrd;
    logic byte_acc;
  } mem_ctl_t;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_CPU = 2'd1,
    ARB_BUSY_AUX = 2'd2
  } arb_state_e;

  // Request fields captured at grant and replayed toward memory.
  typedef struct packed {
    logic              we;
    mem_ctl_t          ctl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the data-memory arbiter: CPU port, aux port and memory port.
// master = arbiter view, slave = surrounding system view.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic              i_cpu_req;
  logic              i_cpu_we;
  mem_ctl_t          i_cpu_ctl;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic              o_cpu_stall;
  logic [DATA_W-1:0] o_cpu_rdata;
  logic              o_cpu_err;

  logic              i_aux_req;
  logic              i_aux_we;
  mem_ctl_t          i_aux_ctl;
  logic [ADDR_W-1:0] i_aux_addr;
  logic [DATA_W-1:0] i_aux_wdata;
  logic              o_aux_ack;
  logic [DATA_W-1:0] o_aux_rdata;
  logic              o_aux_err;

  logic              o_mem_req;
  logic              o_mem_we;
  mem_ctl_t          o_mem_ctl;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;

  modport master (
    input  i_cpu_req, i_cpu_we, i_cpu_ctl, i_cpu_addr, i_cpu_wdata,
    output o_cpu_stall, o_cpu_rdata, o_cpu_err,
    input  i_aux_req, i_aux_we, i_aux_ctl, i_aux_addr, i_aux_wdata,
    output o_aux_ack, o_aux_rdata, o_aux_err,
    output o_mem_req, o_mem_we, o_mem_ctl, o_mem_addr, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    output i_cpu_req, i_cpu_we, i_cpu_ctl, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_stall, o_cpu_rdata, o_cpu_err,
    output i_aux_req, i_aux_we, i_aux_ctl, i_aux_addr, i_aux_wdata,
    input  o_aux_ack, o_aux_rdata, o_aux_err,
    input  o_mem_req, o_mem_we, o_mem_ctl, o_mem_addr, o_mem_wdata,
    output i_mem_ack, i_mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU memory stage and an aux requester,
// with aux starvation control and a busy watchdog that aborts stuck accesses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            i_clk,
  input logic            i_rst_n,
  dmem_arbiter_if.master bus
);

  arb_state_e           state_q, state_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 abandon_q, abandon_d;
  mem_req_t             req_q, req_d;

  logic     busy_c;
  logic     timeout_c;
  logic     starve_hit_c;
  logic     aux_sel_c;
  logic     cpu_done_c;
  logic     cpu_err_c;
  mem_req_t cpu_fields_c;
  mem_req_t aux_fields_c;

  assign cpu_fields_c = '{we: bus.i_cpu_we, ctl: bus.i_cpu_ctl,
                          addr: bus.i_cpu_addr, wdata: bus.i_cpu_wdata};
  assign aux_fields_c = '{we: bus.i_aux_we, ctl: bus.i_aux_ctl,
                          addr: bus.i_aux_addr, wdata: bus.i_aux_wdata};

  assign busy_c       = (state_q != ARB_IDLE);
  // An ack arriving in the expiry cycle completes normally instead of aborting.
  assign timeout_c    = busy_c & (timer_q == TIMER_W'(TIMEOUT_CYCLES)) & ~bus.i_mem_ack;
  assign starve_hit_c = (starve_q == STARVE_W'(STARVE_LIMIT));
  assign aux_sel_c    = bus.i_aux_req & (~bus.i_cpu_req | starve_hit_c);

  // State, latched request, watchdog timer, starvation counter, flush marker.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ARB_IDLE;
      starve_q  <= '0;
      timer_q   <= '0;
      abandon_q <= 1'b0;
      req_q     <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      timer_q   <= timer_d;
      abandon_q <= abandon_d;
      req_q     <= req_d;
    end
  end

  // Grant selection, busy sequencing and counter updates.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    timer_d   = timer_q;
    abandon_d = abandon_q;
    req_d     = req_q;

    case (state_q)
      ARB_IDLE: begin
        if (bus.i_cpu_req || bus.i_aux_req) begin
          timer_d   = '0;
          abandon_d = 1'b0;
          if (aux_sel_c) begin
            state_d  = ARB_BUSY_AUX;
            req_d    = aux_fields_c;
            starve_d = '0;
          end else begin
            state_d = ARB_BUSY_CPU;
            req_d   = cpu_fields_c;
            if (bus.i_aux_req && !starve_hit_c) begin
              starve_d = starve_q + STARVE_W'(1);
            end
          end
        end
      end
      ARB_BUSY_CPU: begin
        timer_d = timer_q + TIMER_W'(1);
        // A flushed CPU access still runs to ack so no store is left half-done.
        if (!bus.i_cpu_req) begin
          abandon_d = 1'b1;
        end
        if (bus.i_mem_ack || timeout_c) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY_AUX: begin
        timer_d = timer_q + TIMER_W'(1);
        if (bus.i_mem_ack || timeout_c) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (!bus.i_aux_req) begin
      starve_d = '0;
    end
  end

  assign cpu_done_c = (state_q == ARB_BUSY_CPU) & bus.i_mem_ack & ~abandon_q;
  assign cpu_err_c  = (state_q == ARB_BUSY_CPU) & timeout_c & ~abandon_q;

  // Memory-side request decode.
  assign bus.o_mem_req   = busy_c;
  assign bus.o_mem_we    = busy_c & req_q.we;
  assign bus.o_mem_ctl   = busy_c ? req_q.ctl   : '0;
  assign bus.o_mem_addr  = busy_c ? req_q.addr  : '0;
  assign bus.o_mem_wdata = busy_c ? req_q.wdata : '0;

  // Requester-side completion decode.
  assign bus.o_cpu_stall = bus.i_cpu_req & ~(cpu_done_c | cpu_err_c);
  assign bus.o_cpu_rdata = cpu_done_c ? bus.i_mem_rdata : '0;
  assign bus.o_cpu_err   = cpu_err_c;

  assign bus.o_aux_ack   = (state_q == ARB_BUSY_AUX) & bus.i_mem_ack;
  assign bus.o_aux_rdata = bus.o_aux_ack ? bus.i_mem_rdata : '0;
  assign bus.o_aux_err   = (state_q == ARB_BUSY_AUX) & timeout_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle comparison against a behavioural
// ownership model, plus literal expectations at the key points of each scenario.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  dmem_arbiter_if bus();

  dmem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(255)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Model: who owns memory (0 none, 1 cpu, 2 aux), cycles spent owning it,
  // CPU grants in a row while aux waits, and whether the CPU walked away.
  int          owner   = 0;
  int          age     = 0;
  int          cpu_run = 0;
  bit          flushed = 1'b0;
  logic        l_we    = 1'b0;
  logic [2:0]  l_ctl   = 3'b000;
  logic [31:0] l_addr  = 32'h0;
  logic [31:0] l_wdata = 32'h0;

  logic        prev_req = 1'b0;
  logic [31:0] grants[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every output at the falling edge, then advance the model.
  task automatic sample();
    logic       inb, tmo, cpu_live, cpu_fin, cpu_ok, aux_own;
    logic [2:0] ctl_v;
    @(negedge clk);
    if (!rst_n) begin
      owner = 0; age = 0; cpu_run = 0; flushed = 1'b0;
    end
    inb      = (owner != 0);
    tmo      = inb && (age == 255) && !bus.i_mem_ack;
    cpu_live = (owner == 1) && !flushed;
    cpu_ok   = cpu_live && bus.i_mem_ack;
    cpu_fin  = cpu_live && (bus.i_mem_ack || tmo);
    aux_own  = (owner == 2);
    ctl_v    = bus.o_mem_ctl;

    chk1 ("mem_req",   bus.o_mem_req, inb);
    chk1 ("mem_we",    bus.o_mem_we, inb && l_we);
    chk32("mem_ctl",   {29'b0, ctl_v}, inb ? {29'b0, l_ctl} : 32'h0);
    chk32("mem_addr",  bus.o_mem_addr, inb ? l_addr : 32'h0);
    chk32("mem_wdata", bus.o_mem_wdata, inb ? l_wdata : 32'h0);
    chk1 ("cpu_stall", bus.o_cpu_stall, bus.i_cpu_req && !cpu_fin);
    chk32("cpu_rdata", bus.o_cpu_rdata, cpu_ok ? bus.i_mem_rdata : 32'h0);
    chk1 ("cpu_err",   bus.o_cpu_err, cpu_live && tmo);
    chk1 ("aux_ack",   bus.o_aux_ack, aux_own && bus.i_mem_ack);
    chk32("aux_rdata", bus.o_aux_rdata, (aux_own && bus.i_mem_ack) ? bus.i_mem_rdata : 32'h0);
    chk1 ("aux_err",   bus.o_aux_err, aux_own && tmo);

    if (bus.o_mem_req && !prev_req) grants.push_back(bus.o_mem_addr);
    prev_req = bus.o_mem_req;

    if (rst_n) begin
      if (owner == 0) begin
        if (bus.i_cpu_req || bus.i_aux_req) begin
          if (bus.i_aux_req && (!bus.i_cpu_req || cpu_run >= 4)) begin
            owner = 2; cpu_run = 0;
            l_we = bus.i_aux_we; l_ctl = bus.i_aux_ctl;
            l_addr = bus.i_aux_addr; l_wdata = bus.i_aux_wdata;
          end else begin
            owner = 1;
            if (bus.i_aux_req && cpu_run < 4) cpu_run++;
            l_we = bus.i_cpu_we; l_ctl = bus.i_cpu_ctl;
            l_addr = bus.i_cpu_addr; l_wdata = bus.i_cpu_wdata;
          end
          age = 0; flushed = 1'b0;
        end
      end else begin
        if (owner == 1 && !bus.i_cpu_req) flushed = 1'b1;
        if (bus.i_mem_ack || age == 255) owner = 0;
        age++;
      end
      if (!bus.i_aux_req) cpu_run = 0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic all_idle();
    bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_ctl = '0;
    bus.i_cpu_addr = 32'h0; bus.i_cpu_wdata = 32'h0;
    bus.i_aux_req = 1'b0; bus.i_aux_we = 1'b0; bus.i_aux_ctl = '0;
    bus.i_aux_addr = 32'h0; bus.i_aux_wdata = 32'h0;
    bus.i_mem_ack = 1'b0; bus.i_mem_rdata = 32'h0;
  endtask

  task automatic cpu_drive(input logic we, input logic [2:0] ctl,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.i_cpu_req = 1'b1; bus.i_cpu_we = we; bus.i_cpu_ctl = mem_ctl_t'(ctl);
    bus.i_cpu_addr = addr; bus.i_cpu_wdata = wdata;
  endtask

  task automatic aux_drive(input logic we, input logic [2:0] ctl,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.i_aux_req = 1'b1; bus.i_aux_we = we; bus.i_aux_ctl = mem_ctl_t'(ctl);
    bus.i_aux_addr = addr; bus.i_aux_wdata = wdata;
  endtask

  initial begin
    logic [31:0] g;
    rst_n = 1'b1;
    all_idle();
    #1 rst_n = 1'b0;

    // Reset: memory side quiet, stall simply follows a pending CPU request.
    bus.i_cpu_req = 1'b1;
    bus.i_mem_ack = 1'b1;
    sample();
    chk1("rst_mem_req", bus.o_mem_req, 1'b0);
    chk1("rst_stall", bus.o_cpu_stall, 1'b1);
    adv();
    cyc();
    rst_n = 1'b1;
    all_idle();
    cyc();

    // 1: CPU load, zero-wait ack -> one stall cycle.
    cpu_drive(1'b0, 3'b000, 32'h100, 32'h0);
    sample();
    chk1("t1_stall_n", bus.o_cpu_stall, 1'b1);
    chk1("t1_req_n", bus.o_mem_req, 1'b0);
    adv();
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hDEADBEEF;
    sample();
    chk1("t1_stall_n1", bus.o_cpu_stall, 1'b0);
    chk32("t1_rdata", bus.o_cpu_rdata, 32'hDEADBEEF);
    chk32("t1_addr", bus.o_mem_addr, 32'h100);
    adv();
    all_idle();
    cyc();

    // 2: both ports saturated -> aux forced in on every fifth grant.
    grants.delete();
    cpu_drive(1'b0, 3'b010, 32'h1000, 32'h0);
    aux_drive(1'b0, 3'b100, 32'h2000, 32'h0);
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h0000_2222;
    for (int i = 0; i < 12; i++) cyc();
    all_idle();
    cyc();
    chk32("t2_ngrants", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      g = (i < grants.size()) ? grants[i] : 32'hFFFF_FFFF;
      chk32($sformatf("t2_grant%0d", i), g, (i == 4) ? 32'h2000 : 32'h1000);
    end

    // 3: slow aux write, CPU arrives mid-way and waits its turn.
    aux_drive(1'b1, 3'b001, 32'h20, 32'h55);
    sample(); chk1("t3_req0", bus.o_mem_req, 1'b0); adv();
    sample();
    chk1("t3_we", bus.o_mem_we, 1'b1);
    chk32("t3_wdata", bus.o_mem_wdata, 32'h55);
    chk32("t3_addr", bus.o_mem_addr, 32'h20);
    adv();
    cpu_drive(1'b0, 3'b000, 32'h300, 32'h0);
    sample(); chk1("t3_stall_a", bus.o_cpu_stall, 1'b1); adv();
    cyc();
    bus.i_mem_ack = 1'b1;
    sample();
    chk1("t3_aux_ack", bus.o_aux_ack, 1'b1);
    chk1("t3_stall_b", bus.o_cpu_stall, 1'b1);
    adv();
    bus.i_aux_req = 1'b0; bus.i_mem_ack = 1'b0;
    sample();
    chk1("t3_aux_ack_once", bus.o_aux_ack, 1'b0);
    chk1("t3_stall_c", bus.o_cpu_stall, 1'b1);
    adv();
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h12345678;
    sample();
    chk32("t3_cpu_addr", bus.o_mem_addr, 32'h300);
    chk32("t3_cpu_rdata", bus.o_cpu_rdata, 32'h12345678);
    adv();
    all_idle();
    cyc();

    // 4: CPU store never acked -> error 255 cycles after request rise.
    cpu_drive(1'b1, 3'b001, 32'h400, 32'hAA);
    cyc();
    for (int k = 0; k < 255; k++) begin
      sample();
      if (k == 0) chk1("t4_rise", bus.o_mem_req, 1'b1);
      if (k == 254) chk1("t4_err_early", bus.o_cpu_err, 1'b0);
      adv();
    end
    sample();
    chk1("t4_err", bus.o_cpu_err, 1'b1);
    chk1("t4_stall", bus.o_cpu_stall, 1'b0);
    chk32("t4_rdata", bus.o_cpu_rdata, 32'h0);
    adv();
    bus.i_cpu_req = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h0BAD;
    sample();
    chk1("t4_late_req", bus.o_mem_req, 1'b0);
    chk32("t4_late_rdata", bus.o_cpu_rdata, 32'h0);
    adv();
    cyc();
    all_idle();
    cyc();

    // 5: CPU flush mid-access, then a fresh request.
    cpu_drive(1'b0, 3'b000, 32'h500, 32'h0);
    cyc();
    bus.i_cpu_req = 1'b0;
    sample(); chk1("t5_busy", bus.o_mem_req, 1'b1); adv();
    cpu_drive(1'b0, 3'b000, 32'h600, 32'h0);
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'hBAD0BAD0;
    sample();
    chk1("t5_stall_old", bus.o_cpu_stall, 1'b1);
    chk32("t5_rdata_old", bus.o_cpu_rdata, 32'h0);
    chk32("t5_addr_old", bus.o_mem_addr, 32'h500);
    adv();
    bus.i_mem_ack = 1'b0;
    sample(); chk1("t5_stall_gap", bus.o_cpu_stall, 1'b1); adv();
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h66666666;
    sample();
    chk32("t5_addr_new", bus.o_mem_addr, 32'h600);
    chk1("t5_stall_new", bus.o_cpu_stall, 1'b0);
    chk32("t5_rdata_new", bus.o_cpu_rdata, 32'h66666666);
    adv();
    all_idle();
    cyc();

    // 6: asynchronous reset while aux owns the port.
    aux_drive(1'b0, 3'b000, 32'h700, 32'h0);
    cyc();
    sample(); chk1("t6_busy", bus.o_mem_req, 1'b1); adv();
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_async_req", bus.o_mem_req, 1'b0);
    chk32("t6_async_addr", bus.o_mem_addr, 32'h0);
    sample();
    adv();
    rst_n = 1'b1;
    bus.i_aux_req = 1'b0;
    sample(); chk1("t6_idle", bus.o_mem_req, 1'b0); adv();
    cpu_drive(1'b0, 3'b100, 32'h800, 32'h0);
    cyc();
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h8888;
    sample(); chk32("t6_after_rdata", bus.o_cpu_rdata, 32'h8888); adv();
    all_idle();
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
